// File: rtl/data_ram_resp.sv
// Word-organised data RAM responder for the MEM-stage load/store bus, with programmable wait states.
// Optional out-of-range error reporting is enabled by defining DATA_RAM_OOR_ERR_EN.
module data_ram_resp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WAIT_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_we_q, req_we_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [3:0]  req_sel_q, req_sel_d;
    logic [31:0] req_data_q, req_data_d;
    logic [31:0] data_q, data_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic                  cur_we;
    logic [31:0]           cur_addr;
    logic [3:0]            cur_sel;
    logic [31:0]           cur_data;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic                  enter_ack;
    logic                  mem_we;
    logic                  unused_addr;

    // With WAIT_CYC=0 the commit happens on the capture edge, so the
    // request must come straight from the inputs rather than the registers.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we   = we_i;
            cur_addr = addr_i;
            cur_sel  = sel_i;
            cur_data = data_i;
        end else begin
            cur_we   = req_we_q;
            cur_addr = req_addr_q;
            cur_sel  = req_sel_q;
            cur_data = req_data_q;
        end
        cur_idx = cur_addr[DEPTH_LOG2+1:2];
    end

    always_comb begin
        req_we_d   = req_we_q;
        req_addr_d = req_addr_q;
        req_sel_d  = req_sel_q;
        req_data_d = req_data_q;
        if (state_q == S_IDLE && ce_i) begin
            req_we_d   = we_i;
            req_addr_d = addr_i;
            req_sel_d  = sel_i;
            req_data_d = data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ce_i) begin
                    cnt_d   = 4'(WAIT_CYC);
                    state_d = (WAIT_CYC == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_ack = (state_d == S_ACK) && (state_q != S_ACK);

    always_comb begin
        ack_d  = (state_d == S_ACK);
        busy_d = (state_d == S_WAIT);
        data_d = data_q;
        err_d  = 1'b0;
        mem_we = 1'b0;
`ifdef DATA_RAM_OOR_ERR_EN
        unused_addr = ^cur_addr[1:0];
        if (enter_ack) begin
            err_d  = |cur_addr[31:DEPTH_LOG2+2];
            mem_we = cur_we && !err_d;
            if (!cur_we) begin
                data_d = err_d ? '0 : mem[cur_idx];
            end
        end
`else
        unused_addr = ^{cur_addr[1:0], cur_addr[31:DEPTH_LOG2+2]};
        if (enter_ack) begin
            mem_we = cur_we;
            if (!cur_we) begin
                data_d = mem[cur_idx];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_sel_q  <= '0;
            req_data_q <= '0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_we_q   <= req_we_d;
            req_addr_q <= req_addr_d;
            req_sel_q  <= req_sel_d;
            req_data_q <= req_data_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Array contents survive reset; only the pending write is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (cur_sel[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
                end
            end
        end
    end

    assign data_o = data_q;
    assign ack_o  = ack_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule
